// File: rtl/down_counter_pkg.sv
// Shared types and helpers for the loadable down-counter/timer.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package down_counter_pkg;

    // Controller states; encodings are fixed so debug views stay stable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_PRESCALE = 4;

    // Bits needed to hold PRESCALE-1 in the prescaler (never less than one).
    function automatic int prescale_width(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/down_counter_prescaler.sv
// Divides enabled RUN cycles by PRESCALE to produce one count step.
// Latency: step asserts on the PRESCALE-th enabled cycle after restart.
// Backpressure: none; holds while run=0, restart reloads immediately.
module down_counter_prescaler
    import down_counter_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic restart,
    output logic step
);

    localparam int            PW  = prescale_width(PRESCALE);
    localparam logic [PW-1:0] TOP = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] pre_cnt;

    // Count TOP..0 on run cycles; wrap to TOP on the step cycle or any restart.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= TOP;
        end else if (restart) begin
            pre_cnt <= TOP;
        end else if (run) begin
            if (pre_cnt == '0) begin
                pre_cnt <= TOP;
            end else begin
                pre_cnt <= pre_cnt - ONE;
            end
        end
    end

    // A restart cycle never yields a step, so a load cannot race a stale count.
    assign step = run && !restart && (pre_cnt == '0);

endmodule

// File: rtl/down_counter.sv
// Loadable down-counter/timer with one-shot and auto-reload modes, terminal-count strobe.
// Latency: load visible next edge; tc_pulse rises on the edge counter_out hits 0 or reloads.
// Backpressure: none; enable gates counting, clear acknowledges DONE.
// Optional prescaler compiled in with DOWN_COUNTER_PRESCALE_EN (PRESCALE cycles per step).
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             clear,
    output logic [WIDTH-1:0] counter_out,
    output logic             zero,
    output logic             tc_pulse,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload_q;
    logic             step;

`ifdef DOWN_COUNTER_PRESCALE_EN
    logic pre_run;
    logic pre_restart;

    // Prescaler only advances while actually counting; leaving RUN or loading re-arms it.
    assign pre_run     = (state == RUN) && enable;
    assign pre_restart = load || (state != RUN);

    down_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (pre_run),
        .restart (pre_restart),
        .step    (step)
    );
`else
    logic unused_prescale;

    // Without the prescaler every enabled cycle is a count step.
    assign unused_prescale = (PRESCALE > 1);
    assign step            = enable;
`endif

    // Controller: load wins over everything but reset; terminal handling over clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter_out <= '0;
            reload_q    <= '0;
            tc_pulse    <= 1'b0;
            state       <= IDLE;
        end else if (load) begin
            counter_out <= load_value;
            reload_q    <= load_value;
            tc_pulse    <= 1'b0;
            state       <= (load_value != '0) ? RUN : IDLE;
        end else begin
            tc_pulse <= 1'b0;
            case (state)
                RUN: begin
                    if (step) begin
                        if (counter_out > ONE) begin
                            counter_out <= counter_out - ONE;
                        end else if (counter_out == ONE) begin
                            tc_pulse <= 1'b1;
                            if (auto_reload) begin
                                counter_out <= reload_q;
                            end else begin
                                counter_out <= '0;
                                state       <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (clear) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status decodes straight off registered state.
    assign zero = (counter_out == '0);
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
